// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_pkg                                              |
// | Brief    : Shared UART definitions (state encoding, line idle    |
// |            level, default frame geometry) for uart_tx/uart_rx.   |
// | Macros   : none                                                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package uart_pkg;

  // Frame-level state encoding; PARITY is only reached when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL    = 1'b1;
  localparam int   UART_DATA_BITS_DEF = 8;
  localparam int   UART_STOP_BITS_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_tx_if                                            |
// | Brief    : Baud tick, byte handshake and serial line bundle for  |
// |            the UART transmitter.                                 |
// | Macros   : none                                                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface uart_tx_if;
  logic       tick;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       txd;
  logic       busy;

  // Producer / parent side: drives the tick and the byte stream.
  modport master (output tick, din, din_valid, input din_ready, txd, busy);
  // Transmitter side.
  modport slave  (input tick, din, din_valid, output din_ready, txd, busy);
endinterface
`default_nettype wire

// File: rtl/uart_tx_hold.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_tx_hold                                          |
// | Brief    : One-entry valid/ready holding register feeding the    |
// |            transmit shifter.                                     |
// | Macros   : none                                                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS_DEF
) (
  input  wire              clk,
  input  wire              rst,
  input  wire  [WIDTH-1:0] i_data,
  input  wire              i_valid,
  output logic             o_ready,
  input  wire              i_take,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Load when empty; the consumer only takes when full, so load and take never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && !r_full) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_ready = !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_tx                                               |
// | Brief    : Tick-paced UART transmitter, LSB first, with a        |
// |            one-byte holding register for gapless frames.         |
// | Macros   : UART_TX_PARITY_EN - insert a parity bit before stop   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int STOP_BITS  = UART_STOP_BITS_DEF,
  parameter int PARITY_ODD = 0
) (
  input wire       clk,
  input wire       rst,
  uart_tx_if.slave bus
);

  localparam logic [2:0] c_last_bit  = 3'(DATA_BITS - 1);
  localparam logic       c_last_stop = 1'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic       c_par_odd   = 1'(PARITY_ODD);
`endif

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 w_take;
  logic                 w_hold_full;
  logic [DATA_BITS-1:0] w_hold_data;
  logic                 w_last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 r_par, w_par_nxt;
`endif

  uart_tx_hold #(.WIDTH(DATA_BITS)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_data  (bus.din[DATA_BITS-1:0]),
    .i_valid (bus.din_valid),
    .o_ready (bus.din_ready),
    .i_take  (w_take),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data)
  );

  assign w_last_stop = (r_stop_cnt == c_last_stop);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: everything advances only on a baud tick.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.tick) begin
      case (r_state)
        ST_IDLE:  if (w_hold_full) w_state_nxt = ST_START;
        ST_START: w_state_nxt = ST_DATA;
        ST_DATA: begin
          if (r_bit_cnt == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: w_state_nxt = ST_STOP;
`endif
        ST_STOP: begin
          if (w_last_stop) w_state_nxt = w_hold_full ? ST_START : ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: TXD level for the coming interval, shifter, counters, hold unload.
  always_comb begin
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_txd_nxt      = r_txd;
    w_take         = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt      = r_par;
`endif
    if (bus.tick) begin
      case (r_state)
        ST_IDLE, ST_STOP: begin
          if ((r_state == ST_STOP) && !w_last_stop) begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
            w_txd_nxt      = UART_IDLE_LEVEL;
          end else if (w_hold_full) begin
            // Start bit; the queued byte moves into the shifter on this edge.
            w_take      = 1'b1;
            w_shift_nxt = w_hold_data;
            w_txd_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = (^w_hold_data) ^ c_par_odd;
`endif
          end else begin
            w_txd_nxt = UART_IDLE_LEVEL;
          end
        end
        ST_START: begin
          w_txd_nxt     = r_shift[0];
          w_bit_cnt_nxt = 3'd0;
        end
        ST_DATA: begin
          if (r_bit_cnt == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
            w_txd_nxt      = r_par;
`else
            w_txd_nxt      = UART_IDLE_LEVEL;
            w_stop_cnt_nxt = 1'b0;
`endif
          end else begin
            w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_txd_nxt     = r_shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          w_txd_nxt      = UART_IDLE_LEVEL;
          w_stop_cnt_nxt = 1'b0;
        end
`endif
        default: w_txd_nxt = UART_IDLE_LEVEL;
      endcase
    end
  end

  // Datapath registers; TXD is registered so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_txd      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_txd      <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign bus.txd  = r_txd;
  assign bus.busy = (r_state != ST_IDLE) || w_hold_full;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It sits directly downstream of the baud tick generator.
- Consumes that generator's one-cycle baud pulse and a byte stream presented with a valid/ready handshake.
- Emits 8N1 frames (8 data bits, no parity, 1 stop bit) on TXD, LSB first.
- A one-byte holding register lets the producer queue the next byte while the current frame shifts, so back-to-back frames have no idle gap.

Parameters:
- DATA_BITS, 8: data bits per frame. Legal range 5..8.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- PARITY_ODD, 0: parity sense. 0 = even, 1 = odd. Only used when UART_TX_PARITY_EN is defined.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: asynchronous, active-high reset.
- TICK, in, 1: one-CLK-cycle baud pulse from the baud generator. The interval between pulses is one bit time.
- DIN, in, 8: byte to send. Bits above DATA_BITS-1 are ignored.
- DIN_VALID, in, 1: DIN is valid. The producer holds DIN stable until accepted.
- DIN_READY, out, 1: holding register empty. A byte is accepted on any CLK edge where DIN_VALID & DIN_READY.
- TXD, out, 1: serial line. Registered output; idle level is 1.
- BUSY, out, 1: high when a frame is in flight or the holding register is full.

Behaviour:
- Reset (async, immediate):
  - TXD=1, DIN_READY=1, BUSY=0, state=IDLE.
  - Holding register empty; shift register and bit counter cleared.
  - A reset mid-frame aborts the frame; TXD returns to 1 immediately. The truncated frame is not retransmitted.
- Holding register:
  - DIN_READY = !hold_full.
  - Load on valid & ready. hold_full is set the following cycle.
  - When a frame starts, the byte moves to the shift register and hold_full clears. DIN_READY rises the next cycle, so there is no same-cycle load/unload.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- All transitions and TXD changes happen only on CLK edges where TICK=1. TXD takes its new value on the edge that samples TICK, so TXD changes in the cycle after the pulse.
- Transitions:
  - IDLE, TICK & hold_full -> START. TXD=0, load shift register.
  - IDLE, TICK & !hold_full -> stay IDLE, TXD=1.
  - No TICK -> no change in any state.
  - START, TICK -> DATA. TXD=shift[0], bit_cnt=0.
  - DATA, TICK -> shift right, bit_cnt+1, TXD=next bit. After bit DATA_BITS-1 -> STOP (or PARITY), TXD=1.
  - STOP, TICK -> count stop bits. After the last one:
    - hold_full -> START directly (no idle interval).
    - otherwise -> IDLE, TXD=1.
- Frame length in TICK intervals = 1 + DATA_BITS + STOP_BITS (+1 with parity).
  - Latency: byte accepted at cycle N with transmitter idle; the first TICK at cycle T>=N+1 drives TXD=0 at T+1.
- BUSY = (state != IDLE) | hold_full.
- DIN_VALID while DIN_READY=0 is held off, not dropped. TICK is ignored while IDLE and the holding register is empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - TXD carries the XOR of the transmitted data bits, XOR PARITY_ODD.
  - Frame grows by one interval (11 for 8N1 becomes 8E1/8O1).
- Undefined: no PARITY state or parity logic; PARITY_ODD is unused.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef (IDLE/START/DATA/PARITY/STOP);
  - UART_IDLE_LEVEL=1'b1;
  - default DATA_BITS/STOP_BITS constants.
- uart_pkg is to be shared with the future uart_rx.
- One natural sub-module: uart_tx_hold, the one-entry valid/ready holding register. The FSM and shifter stay in uart_tx.
- The baud generator is instantiated by the parent, not inside uart_tx.

Test Plan:
- Single byte: DIN=0xA5 with TICK every 16 cycles. TXD per interval must read 0,1,0,1,0,0,1,0,1,1. BUSY high for 10 intervals then low; DIN_READY high again one cycle after frame start.
- Back-to-back: 0x55 then 0x0F, second offered during the first frame. 20 contiguous intervals with no idle interval; the second start bit begins on the tick ending the first stop bit.
- Backpressure: hold DIN_VALID=1 with 3 bytes 0x01, 0x02, 0x03. DIN_READY low while the holding register is full. All three bytes are sent in order; none are lost or duplicated.
- Reset mid-frame: assert RST during data bit 3 of 0xFF. TXD=1 and BUSY=0 immediately. After release, 0x00 sends cleanly.
- No tick: DIN=0x3C accepted, TICK held low for 100 cycles. TXD stays 1, BUSY=1. The first TICK starts the frame.
- UART_TX_PARITY_EN, PARITY_ODD=0: DIN=0xA5 gives parity interval TXD=0. DIN=0x07 gives parity 1. Frame is 11 intervals.
